// File: rtl/regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_ctrl
// Brief    : Sole initiator of the CPU register file. It accepts single
//            read/write requests over valid/ready, drives the register-file
//            ports from flops, and returns read data or a write acknowledge
//            on a valid/ready response channel.
// Options  : REGFILE_PORT_CTRL_SCRUB_EN - when defined, the register file is
//            zero-scrubbed (indices 0..NREG-1) after every reset release.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_port_ctrl #(
  parameter  int NREG = 32,
  parameter  int DW   = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,       // asynchronous, active-low
  // request channel
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_rs1,
  input  logic [AW-1:0] i_req_rs2,
  input  logic [AW-1:0] i_req_rd,
  input  logic [DW-1:0] i_req_wdata,
  // response channel
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_data1,
  output logic [DW-1:0] o_rsp_data2,
  output logic          o_rsp_wr,
  output logic          o_busy,
  // register-file ports
  output logic [AW-1:0] o_rf_rs1,
  output logic [AW-1:0] o_rf_rs2,
  output logic [AW-1:0] o_rf_rd,
  output logic [DW-1:0] o_rf_din,
  output logic          o_rf_rw,
  output logic          o_rf_enable,
  input  logic [DW-1:0] i_rf_out1,
  input  logic [DW-1:0] i_rf_out2
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_RSP   = 3'd3
`ifdef REGFILE_PORT_CTRL_SCRUB_EN
    ,
    ST_SCRUB = 3'd4
`endif
  } state_t;

  state_t        r_state;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data1;
  logic [DW-1:0] r_rsp_data2;
  logic          r_rsp_wr;
  logic          r_busy;
  logic [AW-1:0] r_rf_rs1;
  logic [AW-1:0] r_rf_rs2;
  logic [AW-1:0] r_rf_rd;
  logic [DW-1:0] r_rf_din;
  logic          r_rf_rw;
  logic          r_rf_enable;
`ifdef REGFILE_PORT_CTRL_SCRUB_EN
  logic [AW-1:0] r_scrub_idx;
  logic          r_scrub_done;
`endif

  logic w_accept;

  // A request is taken only while idle and advertising ready.
  assign w_accept = i_req_valid && r_req_ready && (r_state == ST_IDLE);

  // Sequencer: every output is a flop so the register file sees clean,
  // edge-aligned strobes and indices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
`ifdef REGFILE_PORT_CTRL_SCRUB_EN
      r_state      <= ST_SCRUB;
      r_scrub_idx  <= '0;
      r_scrub_done <= 1'b0;
`else
      r_state      <= ST_IDLE;
`endif
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data1  <= '0;
      r_rsp_data2  <= '0;
      r_rsp_wr     <= 1'b0;
      r_busy       <= 1'b0;
      r_rf_rs1     <= '0;
      r_rf_rs2     <= '0;
      r_rf_rd      <= '0;
      r_rf_din     <= '0;
      r_rf_rw      <= 1'b0;
      r_rf_enable  <= 1'b0;
    end else begin
      r_rf_enable <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_rf_rs1    <= i_req_rs1;
            r_rf_rs2    <= i_req_rs2;
            r_rf_rd     <= i_req_rd;
            r_rf_din    <= i_req_wdata;
            if (i_req_we) begin
              // x0 is hard-wired: acknowledge the write but never strobe it
              r_rf_rw <= |i_req_rd;
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_WR: begin
          r_rf_rw     <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_wr    <= 1'b1;
          r_rsp_data1 <= '0;
          r_rsp_data2 <= '0;
          r_state     <= ST_RSP;
        end
        ST_RD: begin
          // Read data is combinational from the indices driven this cycle
          r_rsp_data1 <= (r_rf_rs1 == '0) ? '0 : i_rf_out1;
          r_rsp_data2 <= (r_rf_rs2 == '0) ? '0 : i_rf_out2;
          r_rsp_valid <= 1'b1;
          r_rsp_wr    <= 1'b0;
          r_state     <= ST_RSP;
        end
        ST_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
`ifdef REGFILE_PORT_CTRL_SCRUB_EN
        ST_SCRUB: begin
          if (!r_scrub_done) begin
            r_busy   <= 1'b1;
            r_rf_rw  <= 1'b1;
            r_rf_rd  <= r_scrub_idx;
            r_rf_din <= '0;
            if (r_scrub_idx == AW'(NREG - 1)) begin
              r_scrub_done <= 1'b1;
            end else begin
              r_scrub_idx <= r_scrub_idx + 1'b1;
            end
          end else begin
            // Last strobe completes on this edge; hand over to IDLE ready
            r_rf_rw     <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
`endif
        default: begin
          r_rf_rw     <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data1 = r_rsp_data1;
  assign o_rsp_data2 = r_rsp_data2;
  assign o_rsp_wr    = r_rsp_wr;
  assign o_busy      = r_busy;
  assign o_rf_rs1    = r_rf_rs1;
  assign o_rf_rs2    = r_rf_rs2;
  assign o_rf_rd     = r_rf_rd;
  assign o_rf_din    = r_rf_din;
  assign o_rf_rw     = r_rf_rw;
  assign o_rf_enable = r_rf_enable;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_port_ctrl
// Brief    : Self-checking bench for regfile_port_ctrl. A behavioural
//            register file sits on the rf_* ports; a separate array holds
//            the architectural contents expected from completed requests.
//            Honours REGFILE_PORT_CTRL_SCRUB_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [4:0]  i_req_rs1, i_req_rs2, i_req_rd;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data1, o_rsp_data2;
  logic        o_rsp_wr;
  logic        o_busy;
  logic [4:0]  o_rf_rs1, o_rf_rs2, o_rf_rd;
  logic [31:0] o_rf_din;
  logic        o_rf_rw;
  logic        o_rf_enable;
  logic [31:0] rf_out1, rf_out2;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural register file (environment) and expected contents (model)
  logic [31:0] rf_mem   [32];
  logic [31:0] init_val [32];
  logic [31:0] ref_mem  [32];
  logic        preloaded = 1'b0;

  regfile_port_ctrl #(.NREG(32), .DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_rs1   (i_req_rs1),
    .i_req_rs2   (i_req_rs2),
    .i_req_rd    (i_req_rd),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data1 (o_rsp_data1),
    .o_rsp_data2 (o_rsp_data2),
    .o_rsp_wr    (o_rsp_wr),
    .o_busy      (o_busy),
    .o_rf_rs1    (o_rf_rs1),
    .o_rf_rs2    (o_rf_rs2),
    .o_rf_rd     (o_rf_rd),
    .o_rf_din    (o_rf_din),
    .o_rf_rw     (o_rf_rw),
    .o_rf_enable (o_rf_enable),
    .i_rf_out1   (rf_out1),
    .i_rf_out2   (rf_out2)
  );

  always #5 clk = ~clk;

  // Register file: preload once, then write on enable && rw
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_val[i];
    end else if (o_rf_enable && o_rf_rw) begin
      rf_mem[o_rf_rd] <= o_rf_din;
    end
  end

  assign rf_out1 = rf_mem[o_rf_rs1];
  assign rf_out2 = rf_mem[o_rf_rs2];

  // One complete transaction with full response checking
  task automatic do_txn(input logic we, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] wd,
                        input logic early, input int hold);
    logic [31:0] e1, e2;
    logic        exp_rw;
    int          n;
    int          pulses;
    e1 = 32'h0;
    e2 = 32'h0;
    if (!we) begin
      e1 = (rs1 == 5'd0) ? 32'h0 : ref_mem[rs1];
      e2 = (rs2 == 5'd0) ? 32'h0 : ref_mem[rs2];
    end
    exp_rw = we && (rd != 5'd0);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_rs1   = rs1;
    i_req_rs2   = rs2;
    i_req_rd    = rd;
    i_req_wdata = wd;
    i_rsp_ready = early;
    n = 0;
    while (o_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (o_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_timeout: got %b want 1", o_req_ready);
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_req_we    = 1'($urandom);
    i_req_rs1   = 5'($urandom);
    i_req_rs2   = 5'($urandom);
    i_req_rd    = 5'($urandom);
    i_req_wdata = $urandom;
    @(negedge clk);
    vectors++;
    if (o_rf_rw !== exp_rw) begin
      miscompares++;
      $display("FAIL wr_strobe: got %b want %b (rd=%0d)", o_rf_rw, exp_rw, rd);
    end
    vectors++;
    if (we) begin
      if (o_rf_rd !== rd || o_rf_din !== wd) begin
        miscompares++;
        $display("FAIL wr_port: got rd=%0d din=%h want rd=%0d din=%h", o_rf_rd, o_rf_din, rd, wd);
      end
    end else begin
      if (o_rf_rs1 !== rs1 || o_rf_rs2 !== rs2) begin
        miscompares++;
        $display("FAIL rd_port: got rs1=%0d rs2=%0d want %0d %0d", o_rf_rs1, o_rf_rs2, rs1, rs2);
      end
    end
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_busy !== 1'b1 || o_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL active_cycle: got valid=%b busy=%b ready=%b want 0 1 0", o_rsp_valid, o_busy, o_req_ready);
    end
    pulses = (o_rf_rw === 1'b1) ? 1 : 0;
    n = 1;
    while (o_rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
      pulses += (o_rf_rw === 1'b1) ? 1 : 0;
    end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL latency: got %0d want 2", n);
    end
    vectors++;
    if (o_rsp_wr !== we || o_rsp_data1 !== e1 || o_rsp_data2 !== e2) begin
      miscompares++;
      $display("FAIL response: got wr=%b d1=%h d2=%h want wr=%b d1=%h d2=%h",
               o_rsp_wr, o_rsp_data1, o_rsp_data2, we, e1, e2);
    end
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        pulses += (o_rf_rw === 1'b1) ? 1 : 0;
        vectors++;
        if (o_rsp_valid !== 1'b1 || o_req_ready !== 1'b0 || o_rsp_wr !== we ||
            o_rsp_data1 !== e1 || o_rsp_data2 !== e2) begin
          miscompares++;
          $display("FAIL rsp_hold: got v=%b rdy=%b wr=%b d1=%h d2=%h want 1 0 %b %h %h",
                   o_rsp_valid, o_req_ready, o_rsp_wr, o_rsp_data1, o_rsp_data2, we, e1, e2);
        end
      end
      i_rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_done: got v=%b rdy=%b busy=%b want 0 1 0", o_rsp_valid, o_req_ready, o_busy);
    end
    vectors++;
    if (pulses != (exp_rw ? 1 : 0)) begin
      miscompares++;
      $display("FAIL strobe_count: got %0d want %0d", pulses, exp_rw ? 1 : 0);
    end
    if (exp_rw) ref_mem[rd] = wd;
  endtask

`ifdef REGFILE_PORT_CTRL_SCRUB_EN
  // Follows the post-reset scrub; optionally aborts it with reset at stop_at
  task automatic check_scrub(input int stop_at);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      vectors++;
      if (o_rf_rw !== 1'b1 || o_rf_rd !== 5'(i) || o_rf_din !== 32'h0 ||
          o_busy !== 1'b1 || o_req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL scrub_step: got rw=%b rd=%0d din=%h busy=%b rdy=%b want 1 %0d 0 1 0",
                 o_rf_rw, o_rf_rd, o_rf_din, o_busy, o_req_ready, i);
      end
      if (i == stop_at) begin
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (o_rf_rw !== 1'b0 || o_busy !== 1'b0 || o_rf_rd !== 5'd0) begin
          miscompares++;
          $display("FAIL scrub_abort: got rw=%b busy=%b rd=%0d want 0 0 0", o_rf_rw, o_busy, o_rf_rd);
        end
        return;
      end
    end
    @(negedge clk);
    vectors++;
    if (o_req_ready !== 1'b1 || o_rf_rw !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL scrub_end: got rdy=%b rw=%b busy=%b want 1 0 0", o_req_ready, o_rf_rw, o_busy);
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
  endtask
`endif

  // Waits for the controller to become ready after a reset release
  task automatic post_release();
`ifdef REGFILE_PORT_CTRL_SCRUB_EN
    check_scrub(-1);
`else
    #1;
    vectors++;
    if (o_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge: got %b want 0", o_req_ready);
    end
    @(negedge clk);
    vectors++;
    if (o_req_ready !== 1'b1 || o_rf_enable !== 1'b1 || o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_after_edge: got rdy=%b en=%b busy=%b v=%b want 1 1 0 0",
               o_req_ready, o_rf_enable, o_busy, o_rsp_valid);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({o_req_ready, o_rsp_valid, o_rsp_wr, o_busy, o_rf_rw, o_rf_enable} !== 6'b0 ||
          o_rsp_data1 !== 32'h0 || o_rsp_data2 !== 32'h0 || o_rf_din !== 32'h0 ||
          o_rf_rs1 !== 5'd0 || o_rf_rs2 !== 5'd0 || o_rf_rd !== 5'd0) begin
        miscompares++;
        $display("FAIL reset_values: got ctl=%b d1=%h d2=%h din=%h want all zero",
                 {o_req_ready, o_rsp_valid, o_rsp_wr, o_busy, o_rf_rw, o_rf_enable},
                 o_rsp_data1, o_rsp_data2, o_rf_din);
      end
    end
    reset = 1'b1;
    post_release();
`ifdef REGFILE_PORT_CTRL_SCRUB_EN
    // Abort the scrub at index 10 and confirm it restarts from 0
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_scrub(10);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_scrub(-1);
`endif
  endtask

  task automatic test_directed();
    do_txn(1'b1, 5'd0, 5'd0, 5'd17, 32'd37, 1'b0, 0);
    do_txn(1'b0, 5'd17, 5'd5, 5'd0, 32'h0, 1'b0, 1);
    for (int k = 1; k <= 29; k += 2) begin
      do_txn(1'b1, 5'd0, 5'd0, 5'(k), 32'h1 << k, 1'b1, 0);
      do_txn(1'b1, 5'd0, 5'd0, 5'(k + 1), 32'h40000000 >> k, 1'b1, 0);
      do_txn(1'b0, 5'(k), 5'(k + 1), 5'd0, 32'h0, 1'b1, 0);
    end
  endtask

  task automatic test_x0();
    do_txn(1'b1, 5'd3, 5'd4, 5'd0, 32'hFFFF_FFFF, 1'b0, 0);
    do_txn(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 0);
    do_txn(1'b0, 5'd0, 5'd31, 5'd0, 32'h0, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] wd;
    int          n;
    wd = $urandom;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_rd    = 5'd9;
    i_req_rs1   = 5'd0;
    i_req_rs2   = 5'd0;
    i_req_wdata = wd;
    i_rsp_ready = 1'b0;
    n = 0;
    while (o_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    // Leave a read request pending the whole time
    i_req_we  = 1'b0;
    i_req_rs1 = 5'd9;
    i_req_rs2 = 5'd0;
    i_req_rd  = 5'd0;
    @(negedge clk);
    @(negedge clk);
    for (int h = 0; h < 5; h++) begin
      vectors++;
      if (o_rsp_valid !== 1'b1 || o_rsp_wr !== 1'b1 || o_rsp_data1 !== 32'h0 ||
          o_rsp_data2 !== 32'h0 || o_req_ready !== 1'b0 || o_rf_rw !== 1'b0 || o_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold: got v=%b wr=%b d1=%h d2=%h rdy=%b rw=%b busy=%b want 1 1 0 0 0 0 1",
                 o_rsp_valid, o_rsp_wr, o_rsp_data1, o_rsp_data2, o_req_ready, o_rf_rw, o_busy);
      end
      @(negedge clk);
    end
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b rdy=%b want 0 1", o_rsp_valid, o_req_ready);
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_busy !== 1'b1 || o_req_ready !== 1'b0 || o_rf_rs1 !== 5'd9) begin
      miscompares++;
      $display("FAIL bp_next_accept: got busy=%b rdy=%b rs1=%0d want 1 0 9", o_busy, o_req_ready, o_rf_rs1);
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_wr !== 1'b0 || o_rsp_data1 !== wd || o_rsp_data2 !== 32'h0) begin
      miscompares++;
      $display("FAIL bp_read_back: got v=%b wr=%b d1=%h d2=%h want 1 0 %h 0",
               o_rsp_valid, o_rsp_wr, o_rsp_data1, o_rsp_data2, wd);
    end
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
    ref_mem[9] = wd;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wr();
    logic [31:0] wd;
    int          n;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_rd    = 5'd12;
    i_req_wdata = 32'hDEAD_BEEF;
    i_rsp_ready = 1'b1;
    n = 0;
    while (o_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_rf_rw !== 1'b0 || o_rf_enable !== 1'b0 ||
        o_req_ready !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: got v=%b rw=%b en=%b rdy=%b busy=%b want all 0",
               o_rsp_valid, o_rf_rw, o_rf_enable, o_req_ready, o_busy);
    end
    i_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    post_release();
    // r12 is indeterminate after the aborted write; re-establish it
    wd = $urandom;
    do_txn(1'b1, 5'd0, 5'd0, 5'd12, wd, 1'b1, 0);
    do_txn(1'b0, 5'd12, 5'd9, 5'd0, 32'h0, 1'b0, 2);
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      do_txn(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
             1'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset       = 1'b0;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_rs1   = 5'd0;
    i_req_rs2   = 5'd0;
    i_req_rd    = 5'd0;
    i_req_wdata = 32'h0;
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      init_val[i] = $urandom;
      ref_mem[i]  = init_val[i];
    end
    // non-zero storage behind x0 so reads must force zero
    init_val[0] = init_val[0] | 32'h1;
    ref_mem[0]  = init_val[0];
    @(posedge clk);
    #1;
    preloaded = 1'b1;
    test_reset();
    test_directed();
    test_x0();
    test_backpressure();
    test_reset_mid_wr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
